// File: rtl/a2d_pkg.sv
// Shared types and constants for the round-robin A2D scheduler.
// CNV_LAT = clks from the cycle nxt is accepted to the cycle cnv_cmplt is high.
package a2d_pkg;

    typedef enum logic [1:0] {IDLE, CMD, GAP, READ} state_t;
    typedef enum logic [1:0] {S_IDLE, S_XFER, S_PORCH, S_FIN} spi_state_t;

    localparam logic [2:0] CH_LFT  = 3'd0;
    localparam logic [2:0] CH_RGHT = 3'd4;
    localparam logic [2:0] CH_BATT = 3'd5;

    // One transaction holds SS_n low for 16 periods plus a half-period porch;
    // done trails SS_n by a clk, the FSM reacts a clk later, and GAP adds one.
    function automatic int cnv_lat(input int div_w);
        int p;
        p = 1 << div_w;
        return 2 * (16 * p + p / 2) + 6;
    endfunction

    localparam int CNV_LAT = cnv_lat(5);

    function automatic logic [2:0] next_ch(input logic [2:0] ch);
        case (ch)
            CH_LFT:  return CH_RGHT;
            CH_RGHT: return CH_BATT;
            default: return CH_LFT;
        endcase
    endfunction

endpackage

// File: rtl/spi_mstr16.sv
// 16-bit SPI master: SCLK idles high, MOSI changes on SCLK fall, MISO sampled on rise.
// SS_n falls the clk after wrt; done pulses the clk after SS_n rises; wrt ignored while busy.
module spi_mstr16
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt,
    input  logic [15:0] cmd,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO,
    output logic        done,
    output logic [15:0] rd_data
);

    localparam logic [SCLK_DIV_W-1:0] DIV_HALF = {1'b1, {(SCLK_DIV_W-1){1'b0}}};
    localparam logic [SCLK_DIV_W-1:0] DIV_RISE = {1'b0, {(SCLK_DIV_W-1){1'b1}}};
    localparam logic [SCLK_DIV_W-1:0] DIV_LAST = {SCLK_DIV_W{1'b1}};

    spi_state_t            st;
    logic [SCLK_DIV_W-1:0] div;
    logic [4:0]            nrise;
    logic [15:0]           shreg;

    assign SCLK    = div[SCLK_DIV_W-1];
    assign rd_data = shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= S_IDLE;
            div   <= DIV_LAST;
            nrise <= 5'd0;
            shreg <= 16'h0000;
            SS_n  <= 1'b1;
            MOSI  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (st)
                S_IDLE: begin
                    if (wrt) begin
                        st    <= S_XFER;
                        SS_n  <= 1'b0;
                        div   <= '0;
                        nrise <= 5'd0;
                        shreg <= cmd;
                        MOSI  <= cmd[15];
                    end
                end
                S_XFER: begin
                    div <= div + 1'b1;
                    if (div == DIV_RISE) begin
                        shreg <= {shreg[14:0], MISO};
                        nrise <= nrise + 5'd1;
                    end
                    // End of a period: either fall into the next bit or hold SCLK high for the porch.
                    if (div == DIV_LAST) begin
                        if (nrise == 5'd16) begin
                            st  <= S_PORCH;
                            div <= DIV_HALF;
                        end else begin
                            MOSI <= shreg[15];
                        end
                    end
                end
                S_PORCH: begin
                    if (div == DIV_LAST) begin
                        SS_n <= 1'b1;
                        st   <= S_FIN;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                S_FIN: begin
                    done <= 1'b1;
                    st   <= S_IDLE;
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/a2d_rr_sched.sv
// Round-robin A2D conversion scheduler over channels 0 -> 4 -> 5.
// Each nxt accepted in IDLE yields two SPI transactions and one cnv_cmplt CNV_LAT clks later.
module a2d_rr_sched
    import a2d_pkg::*;
#(
    parameter int SCLK_DIV_W = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    input  logic        MISO,
    output logic        SS_n,
    output logic        SCLK,
    output logic        MOSI,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    output logic        busy
);

    state_t      state, state_nxt;
    logic        wrt;
    logic        done;
    logic [15:0] rd_data;
    logic [2:0]  ch;
    logic [15:0] cmd;
    logic        rd_unused;

    assign cmd       = {2'b00, ch, 11'h000};
    assign rd_unused = ^rd_data[15:12];

    spi_mstr16 #(.SCLK_DIV_W(SCLK_DIV_W)) u_spi (
        .clk     (clk),
        .rst_n   (rst_n),
        .wrt     (wrt),
        .cmd     (cmd),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .done    (done),
        .rd_data (rd_data)
    );

    always_comb begin
        state_nxt = state;
        wrt       = 1'b0;
        case (state)
            IDLE: if (nxt) begin
                state_nxt = CMD;
                wrt       = 1'b1;
            end
            CMD:  if (done) state_nxt = GAP;
            GAP: begin
                state_nxt = READ;
                wrt       = 1'b1;
            end
            READ: if (done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ch        <= CH_LFT;
            lft_ld    <= 12'h000;
            rght_ld   <= 12'h000;
            batt      <= 12'h000;
            cnv_cmplt <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != IDLE);
            cnv_cmplt <= (state == READ) && done;
            // Result load, completion pulse and pointer advance share one edge.
            if ((state == READ) && done) begin
                case (ch)
                    CH_LFT:  lft_ld  <= rd_data[11:0];
                    CH_RGHT: rght_ld <= rd_data[11:0];
                    default: batt    <= rd_data[11:0];
                endcase
                ch <= next_ch(ch);
            end
        end
    end

endmodule

// File: tb/tb_a2d_rr_sched.sv
// Bench for a2d_rr_sched with a behavioural ADC128S-style slave and SPI protocol monitor.
module tb_a2d_rr_sched;
    import a2d_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nxt = 1'b0;
    logic        MISO = 1'b0;
    logic        SS_n, SCLK, MOSI;
    logic [11:0] lft_ld, rght_ld, batt;
    logic        cnv_cmplt, busy;

    always #5 clk = ~clk;

    a2d_rr_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .nxt       (nxt),
        .MISO      (MISO),
        .SS_n      (SS_n),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .batt      (batt),
        .cnv_cmplt (cnv_cmplt),
        .busy      (busy)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ADC model: replies with the channel addressed by the previous complete transaction.
    logic [11:0] adc [0:7];
    logic [15:0] tx, rx;
    int          nr;
    logic [2:0]  last_ch = 3'd0;
    logic        prev_ss = 1'b1, prev_sclk = 1'b1, prev_mosi = 1'b0;
    logic [15:0] rx_q [$];
    int          n_trans = 0, n_cmplt = 0, sclk_viol = 0, mosi_viol = 0;

    always @(negedge clk) begin
        if (prev_ss && !SS_n) begin
            tx = {4'h0, adc[last_ch]};
            MISO = tx[15];
            nr = 0;
            rx = 16'h0000;
            n_trans++;
        end else if (!SS_n) begin
            if (!prev_sclk && SCLK) begin
                rx = {rx[14:0], MOSI};
                nr++;
            end
            if (prev_sclk && !SCLK) begin
                tx = {tx[14:0], 1'b0};
                MISO = tx[15];
            end
            if (prev_sclk && SCLK && (MOSI !== prev_mosi)) mosi_viol++;
        end
        if (!prev_ss && SS_n && rst_n) begin
            checks++;
            if (nr != 16) begin
                errors++;
                $display("FAIL sclk_rises: got %0d expected 16", nr);
            end
            last_ch = rx[13:11];
            rx_q.push_back(rx);
        end
        if (SS_n && !SCLK) sclk_viol++;
        if (cnv_cmplt) n_cmplt++;
        prev_ss   = SS_n;
        prev_sclk = SCLK;
        prev_mosi = MOSI;
    end

    // One single-clk nxt pulse, then wait for cnv_cmplt; pre holds the results one clk earlier.
    task automatic conv(output int lat, output logic [35:0] pre);
        rx_q.delete();
        @(negedge clk);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        lat = 1;
        pre = {lft_ld, rght_ld, batt};
        while (!cnv_cmplt && lat < 3000) begin
            pre = {lft_ld, rght_ld, batt};
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic chk_words(input string name, input logic [15:0] exp);
        logic [15:0] w0, w1;
        w0 = (rx_q.size() > 0) ? rx_q[0] : 16'hxxxx;
        w1 = (rx_q.size() > 1) ? rx_q[1] : 16'hxxxx;
        chk({name, "_ntrans"}, rx_q.size(), 2);
        chk({name, "_cmd_word"}, w0, exp);
        chk({name, "_read_word"}, w1, exp);
    endtask

    typedef struct {
        logic [11:0] adc_lft;
        logic [15:0] cmd;
        logic [11:0] lft, rght, batt;
    } vec_t;

    vec_t tbl [4];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, t, bt, bc;
        logic [35:0] pre, prev_exp;

        tbl[0] = '{12'h123, 16'h0000, 12'h123, 12'h000, 12'h000};
        tbl[1] = '{12'h123, 16'h2000, 12'h123, 12'h456, 12'h000};
        tbl[2] = '{12'h123, 16'h2800, 12'h123, 12'h456, 12'hABC};
        tbl[3] = '{12'h321, 16'h0000, 12'h321, 12'h456, 12'hABC};
        for (int i = 0; i < 8; i++) adc[i] = 12'h000;
        adc[0] = 12'h123;
        adc[4] = 12'h456;
        adc[5] = 12'hABC;

        repeat (2) @(negedge clk);
        chk("rst_SS_n", SS_n, 1'b1);
        chk("rst_SCLK", SCLK, 1'b1);
        chk("rst_MOSI", MOSI, 1'b0);
        chk("rst_results", {lft_ld, rght_ld, batt}, 36'h0);
        chk("rst_cnv_cmplt", cnv_cmplt, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        prev_exp = 36'h0;
        for (int i = 0; i < 4; i++) begin
            adc[0] = tbl[i].adc_lft;
            conv(lat, pre);
            chk($sformatf("v%0d_latency", i), lat, CNV_LAT);
            chk($sformatf("v%0d_pre_results", i), pre, prev_exp);
            chk($sformatf("v%0d_results", i), {lft_ld, rght_ld, batt},
                {tbl[i].lft, tbl[i].rght, tbl[i].batt});
            chk_words($sformatf("v%0d", i), tbl[i].cmd);
            prev_exp = {tbl[i].lft, tbl[i].rght, tbl[i].batt};
            repeat (5) @(negedge clk);
        end

        // Reset in the middle of the channel-4 READ.
        bt = n_trans;
        @(negedge clk);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        t = 0;
        while (n_trans < bt + 2 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("rst_wait_read", (t < 3000), 1'b1);
        repeat (100) @(negedge clk);
        chk("pre_rst_SS_n", SS_n, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_SS_n", SS_n, 1'b1);
        chk("mid_rst_SCLK", SCLK, 1'b1);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_rght", rght_ld, 12'h000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        conv(lat, pre);
        chk("post_rst_latency", lat, CNV_LAT);
        chk("post_rst_results", {lft_ld, rght_ld, batt}, {12'h321, 12'h000, 12'h000});
        chk_words("post_rst", 16'h0000);

        // nxt during CMD and READ must not queue another conversion.
        repeat (5) @(negedge clk);
        bt = n_trans;
        bc = n_cmplt;
        @(negedge clk);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        repeat (20) @(negedge clk);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        t = 0;
        while (n_trans < bt + 2 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (20) @(negedge clk);
        nxt = 1'b1;
        @(negedge clk);
        nxt = 1'b0;
        t = 0;
        while (busy && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (200) @(negedge clk);
        chk("ignore_ntrans", n_trans - bt, 2);
        chk("ignore_ncmplt", n_cmplt - bc, 1);
        chk("ignore_rght", rght_ld, 12'h456);

        // nxt held for 10 back-to-back conversions.
        @(negedge clk);
        nxt = 1'b1;
        lat = 0;
        for (int k = 0; k < 10; k++) begin
            while (lat < 3000) begin
                @(negedge clk);
                lat++;
                if (cnv_cmplt) break;
            end
            chk($sformatf("held%0d_latency", k), lat, CNV_LAT);
            chk($sformatf("held%0d_idle", k), busy, 1'b0);
            if (k == 9) begin
                nxt = 1'b0;
            end else begin
                @(negedge clk);
                lat = 1;
                chk($sformatf("held%0d_restart", k), busy, 1'b1);
            end
        end
        repeat (50) @(negedge clk);
        chk("held_stopped", busy, 1'b0);

        chk("sclk_high_when_idle", sclk_viol, 0);
        chk("mosi_stable_sclk_high", mosi_viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/a2d_rr_sched.md
A2D_RR_SCHED -- requirements
Module: a2d_rr_sched

Interface
REQ-001 SHALL have parameter SCLK_DIV_W, default 5, giving SCLK period = 2^SCLK_DIV_W clk cycles (32).
REQ-002 SHALL have ports in this order:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- nxt  input  1  request one conversion of the current channel.
- MISO  input  1  serial data from the A2D.
- SS_n  output  1  A2D slave select, active low.
- SCLK  output  1  serial clock to the A2D.
- MOSI  output  1  serial data to the A2D.
- lft_ld  output  12  latest channel-0 result.
- rght_ld  output  12  latest channel-4 result.
- batt  output  12  latest channel-5 result.
- cnv_cmplt  output  1  one-clk pulse when a result register updates.
- busy  output  1  high from accepted nxt until cnv_cmplt.

Function
REQ-003 Channel pointer SHALL cycle 0 -> 4 -> 5 -> 0, advancing only on cnv_cmplt.
REQ-004 FSM states SHALL be IDLE, CMD, GAP, READ.
- IDLE: nxt=1 -> CMD, with wrt pulsed to the SPI sub-module.
- CMD: on SPI done -> GAP.
- GAP: one clk, then -> READ, with wrt pulsed.
- READ: on done -> IDLE, with cnv_cmplt pulsed.
REQ-005 The CMD transaction SHALL send {2'b00, ch[2:0], 11'h000}; the READ transaction SHALL send the same word.
REQ-006 On READ completion, rd_data[11:0] SHALL load the register selected by the current pointer; the other two result registers SHALL hold.
REQ-007 nxt SHALL be ignored unless state is IDLE; no queuing.
REQ-008 If nxt is held high, a new conversion SHALL start the cycle after cnv_cmplt (state returns to IDLE for exactly one clk).
REQ-009 busy SHALL equal (state != IDLE).
REQ-010 SPI transaction timing:
- SS_n falls on the clk after wrt.
- SCLK idles high and is driven from the MSB of a divider counter.
- MOSI shifts MSB-first and changes on SCLK fall; MISO is sampled on SCLK rise.
- Exactly 16 SCLK periods occur, followed by a back porch of half an SCLK period.
- SS_n then rises, and done is high for one clk on the cycle after SS_n rises.
REQ-011 The SPI sub-module SHALL ignore wrt while a transaction is in progress.
REQ-012 Each channel conversion SHALL take 2 transactions + 1 GAP clk. Latency from nxt to cnv_cmplt SHALL be a fixed constant, documented in the package as CNV_LAT.

Reset
REQ-013 Asynchronous reset SHALL force state IDLE, pointer 0, SS_n=1, SCLK=1, MOSI=0, lft_ld=rght_ld=batt=0, cnv_cmplt=0, busy=0.
REQ-014 Reset mid-transaction SHALL abort it with no result-register update; the first conversion after release SHALL use channel 0.

Structure
REQ-015 Package a2d_pkg SHALL hold:
- the state enum type;
- channel constants CH_LFT=3'd0, CH_RGHT=3'd4, CH_BATT=3'd5;
- CNV_LAT.
REQ-016 The SPI master SHALL be a separate sub-module, spi_mstr16, with ports clk, rst_n, wrt, cmd[15:0], SS_n, SCLK, MOSI, MISO, done, rd_data[15:0]. All A2D pin outputs SHALL come from it.
REQ-017 All outputs SHALL be registered; no combinational path from MISO to any output.

Verification (bench uses the team ADC128S model, with lft_ld=12'h123, rght_ld=12'h456, batt=12'hABC)
REQ-018 Three single-clk nxt pulses, each sent after the previous cnv_cmplt -> lft_ld=123, then rght_ld=456, then batt=ABC, updated in that order. Each update SHALL coincide with cnv_cmplt, and the first CMD MOSI word SHALL be 16'h0000.
REQ-019 Fourth nxt -> pointer wraps: CMD word 16'h0000; after the model input is changed to 12'h321, lft_ld=321.
REQ-020 nxt pulsed during CMD and again during READ -> no extra transaction; exactly one cnv_cmplt.
REQ-021 nxt held high for 10 conversions -> exactly one IDLE clk between conversions; nxt-to-cnv_cmplt interval equals CNV_LAT every time.
REQ-022 rst_n asserted mid-READ of channel 4 -> SS_n=1 immediately; rght_ld stays 0; the next conversion is channel 0.
REQ-023 SPI protocol check -> SCLK high whenever SS_n=1; exactly 16 SCLK rising edges per SS_n low window; no MOSI change while SCLK is high.
